// File: rtl/saturn_serial_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : saturn_serial_pkg
// Description : Shared constants for the Saturn serial receiver/transmitter:
//               receive state encoding, default bit period and data width.
// Revision    : 1.0 - initial release
// ============================================================================
package saturn_serial_pkg;

    // 115200 baud from a 25 MHz clock
    localparam int c_CLKS_PER_BIT_DEFAULT = 217;
    localparam int c_DATA_W               = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_START = 2'd1;
    localparam state_t c_ST_DATA  = 2'd2;
    localparam state_t c_ST_STOP  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/saturn_serial_rx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : saturn_serial_rx_fifo
// Description : 4-entry byte FIFO for received characters. A push while full
//               is accepted only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module saturn_serial_rx_fifo
    import saturn_serial_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_push,
    input  logic [c_DATA_W-1:0] i_data,
    input  logic                i_pop,
    output logic [c_DATA_W-1:0] o_data,
    output logic                o_empty,
    output logic                o_full
);

    logic [c_DATA_W-1:0] r_mem [4];
    logic [1:0]          r_wr_ptr;
    logic [1:0]          r_rd_ptr;
    logic [2:0]          r_count;
    logic                w_do_pop;
    logic                w_do_push;

    assign o_empty   = (r_count == 3'd0);
    assign o_full    = (r_count == 3'd4);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/saturn_serial_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : saturn_serial_rx
// Description : 8N1 UART receiver, LSB first. Single holding register by
//               default; define SATURN_SERIAL_RX_FIFO_EN to replace it with
//               a 4-entry FIFO (saturn_serial_rx_fifo). Ports are identical.
// Revision    : 1.0 - initial release
// ============================================================================
module saturn_serial_rx
    import saturn_serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_serial_rx,
    input  logic                i_char_ack,
    output logic [c_DATA_W-1:0] o_char_received,
    output logic                o_char_valid,
    output logic                o_frame_error,
    output logic                o_overrun,
    output logic                o_serial_busy
);

    localparam int          c_CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(CLKS_PER_BIT - 1);

    logic [1:0]          r_sync;
    logic                r_rx_prev;
    state_t              r_state;
    state_t              w_state_next;
    logic [c_CW-1:0]     r_cnt;
    logic [c_CW-1:0]     w_cnt_next;
    logic [2:0]          r_bit_cnt;
    logic [c_DATA_W-1:0] r_shift;
    logic                r_frame_err;
    logic                r_overrun;
    logic                w_rx;
    logic                w_fall;
    logic                w_expire;
    logic                w_sample_bit;
    logic                w_stop_ok;
    logic                w_stop_bad;
    logic                w_char_valid;
    logic                w_ack;

    assign w_rx     = r_sync[1];
    assign w_fall   = r_rx_prev & ~w_rx;
    assign w_expire = (r_cnt == '0);
    assign w_ack    = i_char_ack & w_char_valid;

    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], i_serial_rx};
            r_rx_prev <= w_rx;
        end
    end

    // State and bit-period counter registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and counter logic; counter saturates at zero
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_sample_bit = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = c_ST_START;
                    w_cnt_next   = c_HALF;
                end
            end
            c_ST_START: begin
                if (w_expire) begin
                    if (!w_rx) begin
                        w_state_next = c_ST_DATA;
                        w_cnt_next   = c_FULL;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            c_ST_DATA: begin
                if (w_expire) begin
                    w_sample_bit = 1'b1;
                    w_cnt_next   = c_FULL;
                    if (r_bit_cnt == 3'd7) w_state_next = c_ST_STOP;
                end
            end
            c_ST_STOP: begin
                if (w_expire) begin
                    w_stop_ok    = w_rx;
                    w_stop_bad   = ~w_rx;
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Data shift register (LSB arrives first, enters at bit 7) and bit count
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift   <= '0;
            r_bit_cnt <= 3'd0;
        end else begin
            if (r_state == c_ST_START) r_bit_cnt <= 3'd0;
            if (w_sample_bit) begin
                r_shift   <= {w_rx, r_shift[c_DATA_W-1:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // One-cycle framing error pulse after a low stop sample
    always_ff @(posedge i_clk) begin
        if (i_reset) r_frame_err <= 1'b0;
        else         r_frame_err <= w_stop_bad;
    end

`ifdef SATURN_SERIAL_RX_FIFO_EN
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [c_DATA_W-1:0] w_fifo_data;

    saturn_serial_rx_fifo u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_stop_ok),
        .i_data  (r_shift),
        .i_pop   (w_ack),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    assign w_char_valid    = ~w_fifo_empty;
    assign o_char_received = w_fifo_data;

    // Sticky overrun: a byte arrives while full and nothing leaves
    always_ff @(posedge i_clk) begin
        if (i_reset) r_overrun <= 1'b0;
        else if (w_stop_ok && w_fifo_full && !w_ack) r_overrun <= 1'b1;
    end
`else
    logic [c_DATA_W-1:0] r_char;
    logic                r_char_valid;

    // Holding register; a same-cycle ack frees the slot for the new byte
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_char       <= '0;
            r_char_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else if (w_stop_ok) begin
            if (!r_char_valid || w_ack) begin
                r_char       <= r_shift;
                r_char_valid <= 1'b1;
            end else begin
                r_overrun    <= 1'b1;
            end
        end else if (w_ack) begin
            r_char_valid <= 1'b0;
        end
    end

    assign w_char_valid    = r_char_valid;
    assign o_char_received = r_char;
`endif

    assign o_char_valid  = w_char_valid;
    assign o_frame_error = r_frame_err;
    assign o_overrun     = r_overrun;
    assign o_serial_busy = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_saturn_serial_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_saturn_serial_rx
// Description : Self-checking bench for saturn_serial_rx (CLKS_PER_BIT=4).
//               Reference model is a byte queue with capacity 1 (or 4 when
//               SATURN_SERIAL_RX_FIFO_EN is defined) plus a sticky overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_saturn_serial_rx;

    localparam int c_CPB = 4;
`ifdef SATURN_SERIAL_RX_FIFO_EN
    localparam int c_CAP = 4;
`else
    localparam int c_CAP = 1;
`endif

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_serial_rx = 1'b1;
    logic       i_char_ack = 1'b0;
    logic [7:0] o_char_received;
    logic       o_char_valid;
    logic       o_frame_error;
    logic       o_overrun;
    logic       o_serial_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_ovr = 1'b0;

    // Frame-error pulse monitor (sampled on the falling edge)
    int   fe_cycles = 0;
    int   fe_pulses = 0;
    logic fe_prev   = 1'b0;

    saturn_serial_rx #(.CLKS_PER_BIT(c_CPB)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_serial_rx     (i_serial_rx),
        .i_char_ack      (i_char_ack),
        .o_char_received (o_char_received),
        .o_char_valid    (o_char_valid),
        .o_frame_error   (o_frame_error),
        .o_overrun       (o_overrun),
        .o_serial_busy   (o_serial_busy)
    );

    // 100 MHz clock
    always #5 i_clk = ~i_clk;

    // Count frame-error cycles and distinct pulses
    always @(negedge i_clk) begin
        if (o_frame_error) fe_cycles++;
        if (o_frame_error && !fe_prev) fe_pulses++;
        fe_prev = o_frame_error;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_data"},  32'(o_char_received), 32'h00);
        check_val({tag, "_valid"}, 32'(o_char_valid),    32'h0);
        check_val({tag, "_fe"},    32'(o_frame_error),   32'h0);
        check_val({tag, "_ovr"},   32'(o_overrun),       32'h0);
        check_val({tag, "_busy"},  32'(o_serial_busy),   32'h0);
    endtask

    task automatic compare_model(input string tag);
        check_val({tag, "_valid"}, 32'(o_char_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0)
            check_val({tag, "_data"}, 32'(o_char_received), 32'(m_q[0]));
        check_val({tag, "_ovr"}, 32'(o_overrun), 32'(m_ovr));
        check_val({tag, "_busy"}, 32'(o_serial_busy), 32'h0);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ovr = 1'b0;
    endtask

    task automatic model_ack();
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic model_deliver(input logic [7:0] b);
        if (m_q.size() < c_CAP) m_q.push_back(b);
        else                    m_ovr = 1'b1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        tick();
        tick();
        check_reset_outputs("rst");
        i_reset = 1'b0;
        model_reset();
        tick();
    endtask

    // Drive one 8N1 frame. rst_at >= 0 pulses reset on that bit-cycle;
    // ack_end raises the ack in the cycle the byte is handed over.
    task automatic send_frame(input string tag, input logic [7:0] b, input logic stop,
                              input int rst_at, input logic ack_end);
        logic [9:0] bits;
        int         fe_c0;
        int         fe_p0;
        int         exp_fe;
        bits   = {stop, b, 1'b0};
        fe_c0  = fe_cycles;
        fe_p0  = fe_pulses;
        exp_fe = 0;
        for (int c = 0; c < 10 * c_CPB; c++) begin
            i_serial_rx = bits[c / c_CPB];
            i_reset     = (c == rst_at);
            if (rst_at < 0 && c == 20) check_val({tag, "_busy_mid"}, 32'(o_serial_busy), 32'h1);
            tick();
            if (c == rst_at) begin
                check_reset_outputs({tag, "_midrst"});
                model_reset();
            end
        end
        i_serial_rx = 1'b1;
        i_reset     = 1'b0;
        if (ack_end) begin
            tick();
            i_char_ack = 1'b1;
            tick();
            i_char_ack = 1'b0;
            model_ack();
        end
        for (int k = 0; k < 4; k++) tick();
        if (rst_at < 0) begin
            if (stop) model_deliver(b);
            else      exp_fe = 1;
        end
        check_val({tag, "_fe_pulses"}, 32'(fe_pulses - fe_p0), 32'(exp_fe));
        check_val({tag, "_fe_width"},  32'(fe_cycles - fe_c0), 32'(exp_fe));
        compare_model(tag);
    endtask

    task automatic send_glitch();
        int fe_p0;
        fe_p0 = fe_pulses;
        i_serial_rx = 1'b0;
        tick();
        i_serial_rx = 1'b1;
        for (int k = 0; k < 3 * c_CPB; k++) tick();
        check_val("glitch_fe", 32'(fe_pulses - fe_p0), 32'h0);
        compare_model("glitch");
    endtask

    task automatic do_ack();
        i_char_ack = 1'b1;
        tick();
        i_char_ack = 1'b0;
        model_ack();
        tick();
        compare_model("ack");
    endtask

    initial begin
        int op;
        logic [7:0] rb;
        tick();
        do_reset();

        // Clean loopback of 'A'
        send_frame("f41", 8'h41, 1'b1, -1, 1'b0);
        check_val("f41_exact", 32'(o_char_received), 32'h41);
        // One-cycle low glitch
        send_glitch();
        // Bad stop bit
        send_frame("fA5_bad", 8'hA5, 1'b0, -1, 1'b0);
        do_ack();
        do_ack();

        // Two frames, no ack
        do_reset();
        send_frame("f01", 8'h01, 1'b1, -1, 1'b0);
        send_frame("f02", 8'h02, 1'b1, -1, 1'b0);
        check_val("ovr_head", 32'(o_char_received), 32'h01);
        check_val("ovr_flag", 32'(o_overrun), 32'(c_CAP == 1));

        // Ack coincident with delivery
        do_reset();
        send_frame("f10", 8'h10, 1'b1, -1, 1'b0);
        send_frame("f55", 8'h55, 1'b1, -1, 1'b1);
        check_val("same_cyc_data", 32'(o_char_received), 32'h55);

        // Reset in the middle of the data bits, then a clean frame
        send_frame("fFF_rst", 8'hFF, 1'b1, 18, 1'b0);
        send_frame("f3C", 8'h3C, 1'b1, -1, 1'b0);

        // Randomized mix against the model
        do_reset();
        for (int n = 0; n < 40; n++) begin
            op = int'($urandom_range(0, 9));
            rb = 8'($urandom);
            if (op <= 4)      send_frame("rnd_ok",  rb, 1'b1, -1, 1'b0);
            else if (op == 5) send_frame("rnd_bad", rb, 1'b0, -1, 1'b0);
            else if (op == 6) send_glitch();
            else if (op <= 8) do_ack();
            else              send_frame("rnd_ack", rb, 1'b1, -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
